// File: rtl/quad_dec_pkg.sv
// Shared types and helpers for the quadrature decoder: FSM states, Gray positions and the
// transition classifier that turns a (previous, current) phase pair into a step.
package quad_dec_pkg;

   typedef enum logic {INIT, TRACK} state_e;

   // Forward Gray order of {A,B}
   localparam logic [1:0] GRAY0 = 2'b00;
   localparam logic [1:0] GRAY1 = 2'b10;
   localparam logic [1:0] GRAY2 = 2'b11;
   localparam logic [1:0] GRAY3 = 2'b01;

   typedef struct packed {
      logic valid;
      logic dir;
      logic illegal;
   } step_t;

   function automatic logic [1:0] gray_next(input logic [1:0] g);
      logic [1:0] n;
      case (g)
         GRAY0:   n = GRAY1;
         GRAY1:   n = GRAY2;
         GRAY2:   n = GRAY3;
         default: n = GRAY0;
      endcase
      return n;
   endfunction

   function automatic step_t step_dec(input logic [1:0] prev, input logic [1:0] cur);
      step_t r;
      r = '0;
      if (cur != prev) begin
         if ((cur ^ prev) == 2'b11) begin
            r.illegal = 1'b1;
         end else begin
            r.valid = 1'b1;
            r.dir   = (cur == gray_next(prev));
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/qd_glitch_flt.sv
// Per-bit stability filter: the output follows the input only after the new level has been
// held FLT consecutive clocks. Built only when QDEC_FILTER_EN is defined.
`ifdef QDEC_FILTER_EN
module qd_glitch_flt #(
   parameter int unsigned FLT = 3
) (
   input  logic clk_i,
   input  logic clr_i,
   input  logic d_i,
   output logic q_o
);

   logic       q_q, q_d;
   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      q_d   = q_q;
      cnt_d = '0;
      if (d_i != q_q) begin
         if (cnt_q == 4'(FLT - 1)) begin
            q_d = d_i;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         q_q   <= 1'b0;
         cnt_q <= '0;
      end else begin
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign q_o = q_q;

endmodule
`endif

// File: rtl/quad_dec_ud.sv
// Quadrature decoder producing ce/up step strobes plus a loadable M-bit position with wrap
// strobe. Define QDEC_FILTER_EN to insert an FLT-clock glitch filter after the synchronizers.
module quad_dec_ud
   import quad_dec_pkg::*;
#(
   parameter int unsigned M   = 4,
   parameter int unsigned FLT = 3
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         A,
   input  logic         B,
   input  logic         en,
   input  logic         L,
   input  logic [M-1:0] di,
   output logic         ce,
   output logic         up,
   output logic [M-1:0] pos,
   output logic         ovf,
   output logic         err
);

   // INIT waits until samples taken after clr have reached acc, so stale reset zeros in the
   // pipeline are never compared against a real input level.
`ifdef QDEC_FILTER_EN
   localparam int unsigned FillCycles = 2 + FLT;
`else
   localparam int unsigned FillCycles = 2;
`endif
   localparam int unsigned FillW = $clog2(FLT + 3);

   logic [1:0]       s1_q, s2_q, prev_q, prev_d, acc;
   state_e           state_q, state_d;
   logic [FillW-1:0] fill_q, fill_d;
   logic             ce_q, ce_d, up_q, up_d, ovf_q, ovf_d, err_q, err_d;
   logic [M-1:0]     pos_q, pos_d;
   step_t            stp;

`ifdef QDEC_FILTER_EN
   qd_glitch_flt #(.FLT(FLT)) u_flt_a (
      .clk_i (clk),
      .clr_i (clr),
      .d_i   (s2_q[1]),
      .q_o   (acc[1])
   );
   qd_glitch_flt #(.FLT(FLT)) u_flt_b (
      .clk_i (clk),
      .clr_i (clr),
      .d_i   (s2_q[0]),
      .q_o   (acc[0])
   );
`else
   assign acc = s2_q;
`endif

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      prev_d  = acc;
      ce_d    = 1'b0;
      up_d    = up_q;
      pos_d   = pos_q;
      ovf_d   = 1'b0;
      err_d   = err_q;
      stp     = step_dec(prev_q, acc);

      case (state_q)
         INIT: begin
            if (fill_q == FillW'(FillCycles)) begin
               state_d = TRACK;
            end else begin
               fill_d = fill_q + 1'b1;
            end
         end
         TRACK: begin
            if (en) begin
               if (stp.valid) begin
                  ce_d = 1'b1;
                  up_d = stp.dir;
                  if (stp.dir) begin
                     pos_d = pos_q + M'(1);
                     ovf_d = (pos_q == '1);
                  end else begin
                     pos_d = pos_q - M'(1);
                     ovf_d = (pos_q == '0);
                  end
               end
               if (stp.illegal) err_d = 1'b1;
            end
         end
         default: state_d = INIT;
      endcase

      // Load wins over the count; a coincident step still reports ce/up but never wraps
      if (L) begin
         pos_d = di;
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         s1_q    <= 2'b00;
         s2_q    <= 2'b00;
         prev_q  <= 2'b00;
         state_q <= INIT;
         fill_q  <= '0;
         ce_q    <= 1'b0;
         up_q    <= 1'b1;
         pos_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         s1_q    <= {A, B};
         s2_q    <= s1_q;
         prev_q  <= prev_d;
         state_q <= state_d;
         fill_q  <= fill_d;
         ce_q    <= ce_d;
         up_q    <= up_d;
         pos_q   <= pos_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign ce  = ce_q;
   assign up  = up_q;
   assign pos = pos_q;
   assign ovf = ovf_q;
   assign err = err_q;

endmodule

// File: tb/tb_quad_dec_ud.sv
// Scoreboard bench for quad_dec_ud: stimulus queues expected step results with their due
// cycle, a negedge monitor pops and compares on every ce pulse.
module tb_quad_dec_ud;

   localparam int unsigned FLT = 3;
`ifdef QDEC_FILTER_EN
   localparam int LAT = 3 + FLT;
`else
   localparam int LAT = 3;
`endif

   logic       clk = 1'b0;
   logic       clr, A, B, en, L;
   logic [3:0] di;
   logic       ce, up, ovf, err;
   logic [3:0] pos;

   int cyc      = 0;
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int         due;
      logic       up;
      logic [3:0] pos;
      logic       ovf;
      logic       err;
   } exp_t;

   exp_t exp_q[$];

   quad_dec_ud #(.M(4), .FLT(FLT)) dut (
      .clk (clk),
      .clr (clr),
      .A   (A),
      .B   (B),
      .en  (en),
      .L   (L),
      .di  (di),
      .ce  (ce),
      .up  (up),
      .pos (pos),
      .ovf (ovf),
      .err (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Monitor: every ce must match the head of the scoreboard, on its due cycle
   always @(negedge clk) begin
      exp_t e;
      if (ce) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ce", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("ce_cycle", cyc, e.due);
            chk("up", up, e.up);
            chk("pos", pos, e.pos);
            chk("ovf", ovf, e.ovf);
            chk("err", err, e.err);
         end
      end else begin
         chk("ovf_without_ce", ovf, 0);
         if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
            e = exp_q.pop_front();
            chk("missing_ce_due", cyc, e.due);
         end
      end
   end

   task automatic drive_ab(input logic a, input logic b);
      @(posedge clk);
      #1;
      A = a;
      B = b;
   endtask

   task automatic push(input logic u, input logic [3:0] p, input logic o, input logic e);
      exp_q.push_back('{due: cyc + LAT, up: u, pos: p, ovf: o, err: e});
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic step(input logic a, input logic b, input logic exp_ce, input logic u,
                       input logic [3:0] p, input logic o, input logic e);
      drive_ab(a, b);
      if (exp_ce) push(u, p, o, e);
      hold(8);
   endtask

   task automatic load(input logic [3:0] v);
      @(posedge clk);
      #1;
      L  = 1'b1;
      di = v;
      @(posedge clk);
      #1;
      L  = 1'b0;
      @(negedge clk);
      chk("load_pos", pos, v);
   endtask

   initial begin
      clr = 1'b1; A = 1'b0; B = 1'b0; en = 1'b1; L = 1'b0; di = '0;
      hold(3);
      #1 clr = 1'b0;
      hold(10);
      @(negedge clk);
      chk("rst_ce", ce, 0);
      chk("rst_up", up, 1);
      chk("rst_pos", pos, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_err", err, 0);

      // Forward walk 00->10->11->01->00
      step(1, 0, 1, 1, 4'd1, 0, 0);
      step(1, 1, 1, 1, 4'd2, 0, 0);
      step(0, 1, 1, 1, 4'd3, 0, 0);
      step(0, 0, 1, 1, 4'd4, 0, 0);

      // Wrap up and down through the load value
      load(4'hF);
      step(1, 0, 1, 1, 4'h0, 1, 0);
      step(0, 0, 1, 0, 4'hF, 1, 0);

      // Illegal jump: err sticks, pos and up unchanged
      step(1, 1, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      chk("jump_err", err, 1);
      chk("jump_pos", pos, 15);
      chk("jump_up", up, 0);
      step(0, 1, 1, 1, 4'h0, 1, 1);
      step(0, 0, 1, 1, 4'h1, 0, 1);
      @(negedge clk);
      chk("err_sticky", err, 1);

      // clr while A=B=1: first sample afterwards is silent
      @(posedge clk);
      #1;
      clr = 1'b1;
      A   = 1'b1;
      B   = 1'b1;
      hold(3);
      #1 clr = 1'b0;
      hold(14);
      @(negedge clk);
      chk("clr_err", err, 0);
      chk("clr_pos", pos, 0);
      chk("clr_up", up, 1);
      step(0, 1, 1, 1, 4'd1, 0, 0);

      // Enable low: steps are tracked but not counted
      @(posedge clk);
      #1 en = 1'b0;
      step(0, 0, 0, 0, 4'd0, 0, 0);
      step(1, 0, 0, 0, 4'd0, 0, 0);
      step(1, 1, 0, 0, 4'd0, 0, 0);
      @(negedge clk);
      chk("en_off_pos", pos, 1);
      chk("en_off_err", err, 0);
      @(posedge clk);
      #1 en = 1'b1;
      step(0, 1, 1, 1, 4'd2, 0, 0);
      step(1, 1, 1, 0, 4'd1, 0, 0);

      // Load coincident with a wrapping step: load wins, ce still pulses, no ovf
      load(4'hF);
      drive_ab(0, 1);
      push(1, 4'h7, 0, 0);
      hold(LAT - 1);
      #1;
      L  = 1'b1;
      di = 4'h7;
      @(posedge clk);
      #1 L = 1'b0;
      hold(8);
      @(negedge clk);
      chk("load_step_pos", pos, 7);

`ifdef QDEC_FILTER_EN
      // Two-clock glitch on A is swallowed; a stable edge still counts
      @(posedge clk);
      #1 A = 1'b1;
      hold(2);
      #1 A = 1'b0;
      hold(12);
      @(negedge clk);
      chk("glitch_pos", pos, 7);
      step(0, 0, 1, 1, 4'd8, 0, 0);
`endif

      hold(10);
      @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/quad_dec_ud.md
# quad_dec_ud

Quadrature decoder that turns a two-phase encoder signal pair (A/B) into the single-cycle `ce`/`up` step strobes consumed by the team's loadable up/down counters. It also keeps its own loadable M-bit position count with a wrap strobe, so it can run standalone. It sits between board-level encoder pins and the counter chain: it generates the enable/direction stream that the counter chain only consumes.

## Interface
Parameters:
- `M`, 4, width of position count `pos` and load data `di`
- `FLT`, 3, glitch-filter stability depth in clocks (used only with `QDEC_FILTER_EN`; legal 1..15)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `clr`  in  1  reset; synchronous, active-high
- `A`  in  1  encoder phase A, asynchronous
- `B`  in  1  encoder phase B, asynchronous
- `en`  in  1  step enable; 0 suppresses `ce`, `err`, `ovf` and `pos` updates
- `L`  in  1  load `pos` from `di`
- `di`  in  M  load value
- `ce`  out  1  one-cycle step strobe, registered
- `up`  out  1  direction of the last step; 1 = A leads B
- `pos`  out  M  position count
- `ovf`  out  1  one-cycle wrap strobe, coincident with `ce`
- `err`  out  1  sticky illegal-transition flag

## Operation
- A and B each pass through a 2-flop synchronizer. The synchronized pair is `s = {A,B}`.
- Accepted sample `acc`: `s` directly, or the filtered value (see Configuration).
- Forward Gray sequence of {A,B}: 00→10→11→01→00. One step forward gives `ce=1, up=1`. One step backward gives `ce=1, up=0`. No change gives nothing.
- Both bits changing gives `err` set (sticky) and `ce=0`. `prev` still takes `acc`, so the decoder resyncs.
- FSM states:
  - INIT (after `clr`): the first accepted sample loads `prev` with no `ce` and no `err`, then goes to TRACK.
  - TRACK: compare `acc` against `prev` every cycle; `prev <= acc`.
- `en=0`: `prev` keeps tracking; no `ce`, no `err` set, `pos` held (load still works).
- Position count:
  - on a step, `pos ± 1` modulo 2^M.
  - `ovf=1` on 2^M−1→0 counting up, or 0→2^M−1 counting down.
- Load: `L` has priority over a step. `pos <= di`. A coincident step still pulses `ce`/`up`, but `ovf=0`.
- `up` holds its value between steps.
- Reset values: `ce=0, up=1, pos=0, ovf=0, err=0`, synchronizers and `prev` = 0, state INIT, filter counters 0.
- `err` clears only on `clr`.

## Timing
- A/B change setup before edge n gives sync stage 1 at n and stage 2 at n+1.
- Without filter: `ce`, `up`, `pos`, `ovf`, `err` are valid in the cycle after edge n+2 (3-clock latency).
- With filter: a further FLT clocks of stability before `acc` changes, so latency is 3+FLT.
- Maximum step rate without filter: one per clock. Steps faster than one per (FLT+1) clocks are lost or filtered.
- `clr` mid-operation: outputs are at reset values in the next cycle, and the first sample after `clr` never produces `ce`/`err`.
- `L` takes effect at the next edge; `pos` shows `di` in the following cycle.

## Configuration
- `QDEC_FILTER_EN` defined:
  - each synchronized phase feeds a saturating counter.
  - `acc` bit updates only after the new level has been stable FLT consecutive clocks.
  - pulses shorter than FLT are ignored.
- Not defined: `acc = s`, no filter logic, FLT is unused, and latency is fixed at 3.

## Structure
- Package `quad_dec_pkg`:
  - state enum {INIT, TRACK}.
  - Gray-position constants (00, 10, 11, 01).
  - `step_dec` function: (prev, cur) → {valid, dir, illegal}.
- Sub-module `qd_glitch_flt`: per-bit stability filter, parameter FLT, instantiated twice. It is compiled only under `QDEC_FILTER_EN`.

## Test plan
- Reset then forward sequence 00→10→11→01→00, each held 8 clocks, filter off: four `ce` pulses, `up=1`, `pos` 0→4, `ovf=0`, each `ce` 3 clocks after its edge.
- `L=1, di=4'hF` then one forward step: `pos=0`, `ovf=1` for one cycle. Then one backward step: `pos=F`, `ovf=1`, `up=0`.
- Jump 00→11: `err=1`, no `ce`, `pos` unchanged. Then 11→01: normal step, `up=1`, `err` stays 1 until `clr`.
- `clr` while A=B=1, then release: no `ce`/`err` from the first sample. The next change 11→01 gives `ce`, `up=1`, `pos=1`.
- With `QDEC_FILTER_EN`, FLT=3:
  - 2-clock glitch on A gives no `ce`.
  - a stable edge gives `ce` 6 clocks later.
- `en=0` during 3 forward steps: no `ce`, `pos` held. After `en=1`, the next step gives `pos+1` with no error.
